// File: rtl/cmb_event_capture.sv
`default_nettype none
// ============================================================================
// Module   : cmb_event_capture
// Purpose  : Samples the cmb_comb result pads, queues timestamped change events
//            in a show-ahead FIFO and flags/counts overflow drops.
// Options  : define CMB_CAP_DROP_CNT_EN to build the saturating drop counter.
// Revision : 1.0 - initial release
// ============================================================================
module cmb_event_capture #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 12
) (
    input  logic                      clk_pad,
    input  logic                      rst_pad,
    input  logic                      sample_pad,
    input  logic                      q_pad,
    input  logic                      r_pad,
    input  logic                      s_pad,
    input  logic                      t_pad,
    output logic                      evt_valid_pad,
    input  logic                      evt_ready_pad,
    output logic [TS_W+3:0]           evt_data_pad,
    output logic [$clog2(DEPTH):0]    count_pad,
    output logic                      ovf_pad,
    output logic [7:0]                drop_cnt_pad
);

    localparam int              C_PW   = $clog2(DEPTH);
    localparam int              C_CW   = C_PW + 1;
    localparam logic [C_CW-1:0] C_FULL = C_CW'(DEPTH);

    localparam logic [0:0] C_ST_INIT = 1'b0;
    localparam logic [0:0] C_ST_RUN  = 1'b1;

    logic [0:0]      state_q;
    logic [0:0]      state_d;
    logic [3:0]      vec;
    logic [3:0]      prev_q;
    logic [3:0]      prev_d;
    logic            upd_prev;
    logic            push_req;
    logic [TS_W-1:0] ts_q;

    logic [TS_W+3:0] mem_q [DEPTH];
    logic [C_PW-1:0] wr_ptr_q;
    logic [C_PW-1:0] rd_ptr_q;
    logic [C_CW-1:0] count_q;
    logic            ovf_q;

    logic            full;
    logic            pop;
    logic            push_ok;
    logic            drop;

    assign vec = {t_pad, s_pad, r_pad, q_pad};

    // ------------------------------------------------------------------
    // Change-detect FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_pad) begin
        if (rst_pad) begin
            state_q <= C_ST_INIT;
            prev_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_INIT: if (sample_pad) state_d = C_ST_RUN;
            C_ST_RUN:  state_d = C_ST_RUN;
            default:   state_d = C_ST_INIT;
        endcase
    end

    // The baseline follows every differing sample, even when the event is dropped.
    always_comb begin
        upd_prev = 1'b0;
        push_req = 1'b0;
        case (state_q)
            C_ST_INIT: upd_prev = sample_pad;
            C_ST_RUN: begin
                upd_prev = sample_pad && (vec != prev_q);
                push_req = sample_pad && (vec != prev_q);
            end
            default: begin
                upd_prev = 1'b0;
                push_req = 1'b0;
            end
        endcase
    end

    assign prev_d = upd_prev ? vec : prev_q;

    always_ff @(posedge clk_pad) begin
        if (rst_pad) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead event FIFO
    // ------------------------------------------------------------------
    assign full          = (count_q == C_FULL);
    assign evt_valid_pad = (count_q != '0);
    assign pop           = evt_valid_pad && evt_ready_pad;
    assign push_ok       = push_req && (!full || pop);
    assign drop          = push_req && full && !pop;

    // Storage is not reset; the output gate below hides stale entries.
    always_ff @(posedge clk_pad) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {ts_q, vec};
        end
    end

    always_ff @(posedge clk_pad) begin
        if (rst_pad) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + C_PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + C_PW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + C_CW'(1);
                2'b01:   count_q <= count_q - C_CW'(1);
                default: count_q <= count_q;
            endcase
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign evt_data_pad = evt_valid_pad ? mem_q[rd_ptr_q] : '0;
    assign count_pad    = count_q;
    assign ovf_pad      = ovf_q;

`ifdef CMB_CAP_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk_pad) begin
        if (rst_pad) begin
            drop_cnt_q <= 8'h00;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'h01;
        end
    end

    assign drop_cnt_pad = drop_cnt_q;
`else
    assign drop_cnt_pad = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmb_event_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmb_event_capture
// Purpose  : Directed self-checking bench for cmb_event_capture (TS_W=12 and
//            TS_W=4 instances). Drop-count expectation follows CMB_CAP_DROP_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmb_event_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sample;
    logic        ready;
    logic [3:0]  vec;
    logic        valid;
    logic [15:0] data;
    logic [3:0]  count;
    logic        ovf;
    logic [7:0]  drop;

    logic        rst4;
    logic        sample4;
    logic        ready4;
    logic [3:0]  vec4;
    logic        valid4;
    logic [7:0]  data4;
    logic [3:0]  count4;
    logic        ovf4;
    logic [7:0]  drop4;

    logic [15:0] exp_data;
    int n_checks = 0;
    int n_errors = 0;

`ifdef CMB_CAP_DROP_CNT_EN
    localparam logic [7:0] C_EXP_DROP = 8'd2;
`else
    localparam logic [7:0] C_EXP_DROP = 8'd0;
`endif

    cmb_event_capture #(.DEPTH(8), .TS_W(12)) u_dut (
        .clk_pad       (clk),
        .rst_pad       (rst),
        .sample_pad    (sample),
        .q_pad         (vec[0]),
        .r_pad         (vec[1]),
        .s_pad         (vec[2]),
        .t_pad         (vec[3]),
        .evt_valid_pad (valid),
        .evt_ready_pad (ready),
        .evt_data_pad  (data),
        .count_pad     (count),
        .ovf_pad       (ovf),
        .drop_cnt_pad  (drop)
    );

    cmb_event_capture #(.DEPTH(8), .TS_W(4)) u_dut4 (
        .clk_pad       (clk),
        .rst_pad       (rst4),
        .sample_pad    (sample4),
        .q_pad         (vec4[0]),
        .r_pad         (vec4[1]),
        .s_pad         (vec4[2]),
        .t_pad         (vec4[3]),
        .evt_valid_pad (valid4),
        .evt_ready_pad (ready4),
        .evt_data_pad  (data4),
        .count_pad     (count4),
        .ovf_pad       (ovf4),
        .drop_cnt_pad  (drop4)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; sample = 1'b0; ready = 1'b0; vec = 4'b0000;
        rst4 = 1'b1; sample4 = 1'b0; ready4 = 1'b0; vec4 = 4'b0000;
        exp_data = '0;
        tick(); tick();

        // Reset state
        check_eq("rst_valid", {31'd0, valid}, 32'd0);
        check_eq("rst_data",  {16'd0, data},  32'd0);
        check_eq("rst_count", {28'd0, count}, 32'd0);
        check_eq("rst_ovf",   {31'd0, ovf},   32'd0);
        check_eq("rst_drop",  {24'd0, drop},  32'd0);

        // Baseline then a single change at timestamp 5
        rst = 1'b0; sample = 1'b1; vec = 4'b1010;
        tick();
        check_eq("base_valid", {31'd0, valid}, 32'd0);
        check_eq("base_count", {28'd0, count}, 32'd0);
        sample = 1'b0;
        repeat (4) tick();
        sample = 1'b1; vec = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            tick();
            sample = 1'b0;
            check_eq("single_valid", {31'd0, valid}, 32'd1);
            check_eq("single_data",  {16'd0, data},  32'h005B);
            check_eq("single_count", {28'd0, count}, 32'd1);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check_eq("pop_valid", {31'd0, valid}, 32'd0);
        check_eq("pop_count", {28'd0, count}, 32'd0);
        sample = 1'b1; vec = 4'b1011;
        tick();
        sample = 1'b0;
        check_eq("same_vec_valid", {31'd0, valid}, 32'd0);

        // Overflow: baseline plus 10 alternating changes with no consumer
        rst = 1'b1; tick(); tick();
        rst = 1'b0; sample = 1'b1; vec = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            vec = (k % 2 != 0) ? 4'b0001 : 4'b0000;
        end
        tick();
        check_eq("ovf_count", {28'd0, count}, 32'd8);
        check_eq("ovf_flag",  {31'd0, ovf},   32'd1);
        check_eq("ovf_drop",  {24'd0, drop},  {24'd0, C_EXP_DROP});

        // Full with push and pop together, then drain everything
        vec = 4'b0101; ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_data = {12'(i + 1), ((i + 1) % 2 != 0) ? 4'b0001 : 4'b0000};
            else       exp_data = {12'd11, 4'b0101};
            check_eq("drain_valid", {31'd0, valid}, 32'd1);
            check_eq("drain_data",  {16'd0, data},  {16'd0, exp_data});
            if (i == 1) begin
                check_eq("pp_count", {28'd0, count}, 32'd8);
                check_eq("pp_drop",  {24'd0, drop},  {24'd0, C_EXP_DROP});
            end
            tick();
            sample = 1'b0;
        end
        ready = 1'b0;
        check_eq("drain_empty_valid", {31'd0, valid}, 32'd0);
        check_eq("drain_empty_count", {28'd0, count}, 32'd0);

        // Reset with 5 queued events, then re-baseline
        rst = 1'b1; tick(); tick();
        rst = 1'b0; sample = 1'b1; vec = 4'b0000;
        for (int k = 1; k <= 5; k++) begin
            tick();
            vec = (k % 2 != 0) ? 4'b0001 : 4'b0000;
        end
        tick();
        sample = 1'b0;
        check_eq("q5_count", {28'd0, count}, 32'd5);
        rst = 1'b1;
        tick();
        check_eq("midrst_valid", {31'd0, valid}, 32'd0);
        check_eq("midrst_count", {28'd0, count}, 32'd0);
        check_eq("midrst_data",  {16'd0, data},  32'd0);
        check_eq("midrst_ovf",   {31'd0, ovf},   32'd0);
        check_eq("midrst_drop",  {24'd0, drop},  32'd0);
        rst = 1'b0; sample = 1'b1; vec = 4'b1111;
        tick();
        check_eq("rebase_valid", {31'd0, valid}, 32'd0);
        check_eq("rebase_count", {28'd0, count}, 32'd0);
        vec = 4'b0000;
        tick();
        sample = 1'b0;
        check_eq("rebase_evt_valid", {31'd0, valid}, 32'd1);
        check_eq("rebase_evt_data",  {16'd0, data},  32'h0010);
        check_eq("rebase_evt_drop",  {24'd0, drop},  32'd0);

        // Timestamp wrap on the 4-bit timestamp instance
        rst4 = 1'b0;
        tick(); tick();
        sample4 = 1'b1; vec4 = 4'b0000;
        tick();
        sample4 = 1'b0;
        check_eq("wrap_base_valid", {31'd0, valid4}, 32'd0);
        repeat (14) tick();
        sample4 = 1'b1; vec4 = 4'b1000;
        tick();
        sample4 = 1'b0;
        check_eq("wrap_valid", {31'd0, valid4}, 32'd1);
        check_eq("wrap_data",  {24'd0, data4},  32'h18);
        check_eq("wrap_count", {28'd0, count4}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmb_event_capture.md
# cmb_event_capture

Sequential capture stage directly downstream of the `cmb_comb` combinational block. It samples the four `cmb_comb` result pads every enabled cycle and detects changes against the last sample. Each change is queued as a timestamped event record in a show-ahead FIFO, which a consumer drains over a valid/ready handshake. Overflow is flagged and counted.

## Interface
- `DEPTH`, 8 — number of FIFO entries; power of two, ≥2.
- `TS_W`, 12 — width of the free-running timestamp.
- `clk_pad`  in  1  — the single clock; all state updates on its rising edge.
- `rst_pad`  in  1  — synchronous, active-high reset.
- `sample_pad`  in  1  — when high, the result vector is sampled this cycle.
- `q_pad`, `r_pad`, `s_pad`, `t_pad`  in  1 each  — `cmb_comb` outputs. Result vector `vec = {t_pad, s_pad, r_pad, q_pad}`.
- `evt_valid_pad`  out  1  — FIFO head holds a valid event.
- `evt_ready_pad`  in  1  — consumer accepts the head event.
- `evt_data_pad`  out  TS_W+4  — `{timestamp, vec}`, with vec in the 4 LSBs.
- `count_pad`  out  $clog2(DEPTH)+1  — current FIFO occupancy.
- `ovf_pad`  out  1  — sticky flag: at least one event was dropped.
- `drop_cnt_pad`  out  8  — number of dropped events, saturating.

## Operation
- **Clock and reset.** One clock domain. Reset is synchronous and active-high.
- **Reset values.** `evt_valid_pad`=0, `evt_data_pad`=0, `count_pad`=0, `ovf_pad`=0, `drop_cnt_pad`=0. Internally: timestamp=0, baseline `prev`=4'b0000, FSM=INIT.
- **Timestamp.** Increments by 1 every cycle rt_pad is low. Wraps from 2^TS_W−1 to 0 with no flag.
- **FSM states:**
  - INIT: on `sample_pad`, `prev`←vec and go to RUN. No event is generated.
  - RUN: on `sample_pad` with vec≠`prev`, form event `{ts, vec}` and set `prev`←vec. On `sample_pad` with vec==`prev`, nothing happens.
- **Push.** The event formed in a cycle is pushed into the FIFO at that same edge.
- **Pop.** Occurs when `evt_valid_pad` && `evt_ready_pad`.
- **Full-FIFO push:**
  - Full, no pop: the event is dropped. `ovf_pad`←1, `drop_cnt_pad` increments and saturates at 255. `prev` still updates to vec.
  - Full with a pop in the same cycle: the push is accepted and `count_pad` stays at DEPTH.
- **Empty-FIFO push.** No combinational bypass; the event appears at the output on the next cycle.
- **Pop on empty.** Ignored, because `evt_ready_pad` is don't-care while `evt_valid_pad`=0.
- **Output stability.** `evt_data_pad` is held stable while `evt_valid_pad`=1 and `evt_ready_pad`=0.
- **Pointers.** Read and write pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is tracked in `count_pad`.
- **Reset mid-operation.** Flushes the FIFO with no partial pop. Returns the FSM to INIT, so the next sample re-baselines without emitting an event.

## Timing
- **Sample to valid.** 1 cycle. A change sampled at edge N is on `evt_valid_pad`/`evt_data_pad` after edge N, when the FIFO was empty.
- **Timestamp value.** The recorded timestamp is the counter value in the cycle before edge N, i.e. the sampling cycle.
- **Throughput.** One push and one pop per cycle, sustained.
- **`count_pad`** is registered and reflects the push and pop of the previous edge.
- **`ovf_pad` and `drop_cnt_pad`** update at the edge of the dropped push.
- **Input paths.** `q_pad`..`t_pad` reach only registers: no combinational path from inputs to outputs.
- **Handshake path.** `evt_ready_pad` affects outputs only at the next edge.

## Configuration
- **Macro:** `CMB_CAP_DROP_CNT_EN`.
- **Defined:** the 8-bit saturating `drop_cnt_pad` counter is implemented as described.
- **Undefined:** the counter is not built and `drop_cnt_pad` is tied to 8'h00. `ovf_pad` behaviour is unchanged.

## Test plan
- **Baseline, no event.** Reset, then `sample_pad`=1 with vec=4'b1010 → no event, FSM in RUN, `count_pad`=0.
- **Single change.** From baseline 4'b1010, sample 4'b1011 with timestamp=5 and `evt_ready_pad`=0 → next cycle `evt_valid_pad`=1, `evt_data_pad`={12'd5, 4'b1011}, held stable for 3 cycles, then popped on `evt_ready_pad`=1.
- **Overflow.** DEPTH=8, `evt_ready_pad`=0, 10 alternating samples after baseline → `count_pad`=8, `ovf_pad`=1, `drop_cnt_pad`=2. Draining yields the first 8 events in order.
- **Full with simultaneous push and pop.** Push and pop in the same cycle while full → `count_pad` stays 8, no drop, and the new event is last out.
- **Timestamp wrap.** TS_W=4, run 20 cycles and sample a change at cycle 17 → recorded timestamp 4'd1.
- **Mid-operation reset.** Assert `rst_pad` with 5 queued events → next cycle `evt_valid_pad`=0 and `count_pad`=0. The next sample emits no event. The same test is repeated with `CMB_CAP_DROP_CNT_EN` undefined, where `drop_cnt_pad` must stay 0.
